// File: rtl/player_key_decoder.sv
// player_key_decoder
// Resolves the four keycode slots of a USB keyboard report into per-player
// direction codes, jump-held levels and frame-aligned one-shot jump requests
// for the FireBoy and IceGirl controllers. The two players share only the
// key sampling and frame-tick logic; their decode state is fully independent.
module player_key_decoder #(
    parameter logic [7:0] FB_LEFT  = 8'h04,
    parameter logic [7:0] FB_RIGHT = 8'h07,
    parameter logic [7:0] FB_JUMP  = 8'h1A,
    parameter logic [7:0] IG_LEFT  = 8'h50,
    parameter logic [7:0] IG_RIGHT = 8'h4F,
    parameter logic [7:0] IG_JUMP  = 8'h52
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       freeze,
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    output logic [7:0] fb_keycode,
    output logic [7:0] ig_keycode,
    output logic       fb_jump_held,
    output logic       ig_jump_held,
    output logic       fb_jump_req,
    output logic       ig_jump_req,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    // Bit positions inside the key history vectors
    localparam int K_FB_L = 0;
    localparam int K_FB_R = 1;
    localparam int K_FB_J = 2;
    localparam int K_IG_L = 3;
    localparam int K_IG_R = 4;
    localparam int K_IG_J = 5;

    // True when any report slot carries the given code; the empty code never matches
    function automatic logic slot_hit(
        input logic [7:0] code,
        input logic [7:0] s0,
        input logic [7:0] s1,
        input logic [7:0] s2,
        input logic [7:0] s3
    );
        return (code != 8'h00) &&
               ((s0 == code) || (s1 == code) || (s2 == code) || (s3 == code));
    endfunction

    // Most-recently-pressed direction arbitration; a same-cycle tie goes to LEFT
    function automatic dir_t dir_next(
        input dir_t cur,
        input logic rise_l,
        input logic rise_r,
        input logic now_l,
        input logic now_r
    );
        dir_t nxt;
        nxt = cur;
        if (rise_l) begin
            nxt = DIR_LEFT;
        end else if (rise_r) begin
            nxt = DIR_RIGHT;
        end else begin
            case (cur)
                DIR_LEFT:  nxt = now_l ? DIR_LEFT  : (now_r ? DIR_RIGHT : DIR_NONE);
                DIR_RIGHT: nxt = now_r ? DIR_RIGHT : (now_l ? DIR_LEFT  : DIR_NONE);
                default:   nxt = DIR_NONE;
            endcase
        end
        return nxt;
    endfunction

    // Maps a direction state onto the controller's keycode space
    function automatic logic [7:0] dir_code(
        input dir_t       d,
        input logic [7:0] left_code,
        input logic [7:0] right_code
    );
        logic [7:0] code;
        case (d)
            DIR_LEFT:  code = left_code;
            DIR_RIGHT: code = right_code;
            default:   code = 8'h00;
        endcase
        return code;
    endfunction

    logic [5:0] key_hit_s;
    logic [5:0] key_now_r;
    logic [5:0] key_prev_r;
    logic [5:0] rise_s;

    logic       frame_sync_r;
    logic       frame_d_r;
    logic       frame_tick_r;
    logic       frame_tick_next_s;

    dir_t       fb_dir_r;
    dir_t       ig_dir_r;
    dir_t       fb_dir_next_s;
    dir_t       ig_dir_next_s;
    logic       fb_pend_r;
    logic       ig_pend_r;
    logic       fb_req_next_s;
    logic       ig_req_next_s;

    logic [7:0] fb_keycode_r;
    logic [7:0] ig_keycode_r;
    logic       fb_jump_held_r;
    logic       ig_jump_held_r;
    logic       fb_jump_req_r;
    logic       ig_jump_req_r;

    // Combinational slot match for each of the six codes
    always_comb begin
        key_hit_s         = 6'b000000;
        key_hit_s[K_FB_L] = slot_hit(FB_LEFT,  keycode_0, keycode_1, keycode_2, keycode_3);
        key_hit_s[K_FB_R] = slot_hit(FB_RIGHT, keycode_0, keycode_1, keycode_2, keycode_3);
        key_hit_s[K_FB_J] = slot_hit(FB_JUMP,  keycode_0, keycode_1, keycode_2, keycode_3);
        key_hit_s[K_IG_L] = slot_hit(IG_LEFT,  keycode_0, keycode_1, keycode_2, keycode_3);
        key_hit_s[K_IG_R] = slot_hit(IG_RIGHT, keycode_0, keycode_1, keycode_2, keycode_3);
        key_hit_s[K_IG_J] = slot_hit(IG_JUMP,  keycode_0, keycode_1, keycode_2, keycode_3);
    end

    assign rise_s            = key_now_r & ~key_prev_r;
    assign frame_tick_next_s = frame_sync_r & ~frame_d_r;

    assign fb_dir_next_s = dir_next(fb_dir_r, rise_s[K_FB_L], rise_s[K_FB_R],
                                    key_now_r[K_FB_L], key_now_r[K_FB_R]);
    assign ig_dir_next_s = dir_next(ig_dir_r, rise_s[K_IG_L], rise_s[K_IG_R],
                                    key_now_r[K_IG_L], key_now_r[K_IG_R]);

    // A jump fires on the tick if a press is pending or arrives right now
    assign fb_req_next_s = frame_tick_next_s & (fb_pend_r | rise_s[K_FB_J]);
    assign ig_req_next_s = frame_tick_next_s & (ig_pend_r | rise_s[K_IG_J]);

    // Key history and frame-edge detection; keeps running through freeze
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_now_r    <= 6'b000000;
            key_prev_r   <= 6'b000000;
            frame_sync_r <= 1'b0;
            frame_d_r    <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            key_now_r    <= key_hit_s;
            key_prev_r   <= key_now_r;
            // frame_clk comes from another clock domain, so it is captured
            // once before the edge detector looks at it
            frame_sync_r <= frame_clk;
            frame_d_r    <= frame_sync_r;
            frame_tick_r <= frame_tick_next_s;
        end
    end

    // FireBoy direction state, pending jump and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset || freeze) begin
            fb_dir_r       <= DIR_NONE;
            fb_pend_r      <= 1'b0;
            fb_keycode_r   <= 8'h00;
            fb_jump_held_r <= 1'b0;
            fb_jump_req_r  <= 1'b0;
        end else begin
            fb_dir_r       <= fb_dir_next_s;
            fb_keycode_r   <= dir_code(fb_dir_next_s, FB_LEFT, FB_RIGHT);
            fb_jump_held_r <= key_now_r[K_FB_J];
            fb_jump_req_r  <= fb_req_next_s;
            if (fb_req_next_s) begin
                fb_pend_r <= 1'b0;
            end else if (rise_s[K_FB_J]) begin
                fb_pend_r <= 1'b1;
            end else begin
                fb_pend_r <= fb_pend_r;
            end
        end
    end

    // IceGirl direction state, pending jump and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset || freeze) begin
            ig_dir_r       <= DIR_NONE;
            ig_pend_r      <= 1'b0;
            ig_keycode_r   <= 8'h00;
            ig_jump_held_r <= 1'b0;
            ig_jump_req_r  <= 1'b0;
        end else begin
            ig_dir_r       <= ig_dir_next_s;
            ig_keycode_r   <= dir_code(ig_dir_next_s, IG_LEFT, IG_RIGHT);
            ig_jump_held_r <= key_now_r[K_IG_J];
            ig_jump_req_r  <= ig_req_next_s;
            if (ig_req_next_s) begin
                ig_pend_r <= 1'b0;
            end else if (rise_s[K_IG_J]) begin
                ig_pend_r <= 1'b1;
            end else begin
                ig_pend_r <= ig_pend_r;
            end
        end
    end

    assign fb_keycode   = fb_keycode_r;
    assign ig_keycode   = ig_keycode_r;
    assign fb_jump_held = fb_jump_held_r;
    assign ig_jump_held = ig_jump_held_r;
    assign fb_jump_req  = fb_jump_req_r;
    assign ig_jump_req  = ig_jump_req_r;
    assign frame_tick   = frame_tick_r;

endmodule
